// File: rtl/sdram_pkg.sv
// Shared SDRAM arbiter constants and the scanout reader state encoding.
package sdram_pkg;
  localparam int SDRAM_ADDR_W = 26;
  localparam int BURST_WORDS  = 16;
  localparam int BURST_BYTES  = 64;

  typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} scanout_state_t;
endpackage

// File: rtl/stream_fifo.sv
// Synchronous show-ahead FIFO: head word is visible on rdata whenever valid.
// Flush empties it in one cycle; pushes while full are dropped.
module stream_fifo #(
  parameter int DEPTH = 64,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = level == LW'(DEPTH);
  assign valid   = level != '0;
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage carries no reset; only pointers and level define contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/sdram_scanout_reader.sv
// Read-only streaming master: consecutive 64-byte burst reads into a FIFO,
// drained on a valid/ready stream. Define SDRAM_SCANOUT_LOOP_EN for continuous scanout.
module sdram_scanout_reader
  import sdram_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int COUNT_W    = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic [25:0]                   base_addr,
  input  logic [COUNT_W-1:0]            num_bursts,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          m_request,
  input  logic                          m_ready,
  output logic                          m_write,
  output logic                          m_burst,
  output logic [25:0]                   m_address,
  output logic [31:0]                   m_wdata,
  output logic [3:0]                    m_wstrb,
  input  logic                          m_rvalid,
  input  logic [25:0]                   m_raddress,
  input  logic [31:0]                   m_rdata,
  input  logic                          m_complete,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int WC_W  = $clog2(BURST_WORDS);

  scanout_state_t            state, state_n;
  logic [SDRAM_ADDR_W-1:0]   cur_addr, base_q;
  logic [COUNT_W-1:0]        remaining, count_q;
  logic [WC_W-1:0]           word_cnt;
  logic                      load, accept, push, flush, burst_end, reload, done_n;
  logic                      fifo_full, space_ok;
  logic                      unused_bits;

  assign unused_bits = ^{m_raddress, base_addr[5:0]};

  assign m_write   = 1'b0;
  assign m_burst   = 1'b1;
  assign m_wdata   = '0;
  assign m_wstrb   = '0;
  assign m_address = cur_addr;
  assign busy      = state != IDLE;
  assign space_ok  = (LVL_W'(FIFO_DEPTH) - fifo_level) >= LVL_W'(BURST_WORDS);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    accept    = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;
    burst_end = 1'b0;
    reload    = 1'b0;
    done_n    = 1'b0;
    case (state)
      IDLE: if (start && !stop) begin
        if (num_bursts == '0) done_n = 1'b1;
        else begin
          load    = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        accept = m_request && m_ready;
        // A request accepted in the stop cycle still owes us a burst.
        if (stop) begin
          flush   = 1'b1;
          state_n = accept ? DRAIN : IDLE;
        end else if (accept) state_n = DATA;
      end
      DATA: begin
        push      = m_rvalid;
        burst_end = m_rvalid && m_complete;
        if (burst_end && stop) begin
          flush   = 1'b1;
          state_n = IDLE;
        end else if (burst_end) begin
          if (remaining == COUNT_W'(1)) begin
            done_n = 1'b1;
`ifdef SDRAM_SCANOUT_LOOP_EN
            reload  = 1'b1;
            state_n = REQ;
`else
            state_n = IDLE;
`endif
          end else state_n = REQ;
        end else if (stop) state_n = DRAIN;
      end
      DRAIN: if (m_rvalid && m_complete) begin
        flush   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr  <= '0;
      base_q    <= '0;
      remaining <= '0;
      count_q   <= '0;
      word_cnt  <= '0;
      m_request <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done      <= done_n;
      // Space is only judged in REQ, where no burst is in flight to race the level.
      m_request <= (state == REQ) && !stop && !accept && (m_request || space_ok);
      if (load) begin
        cur_addr  <= {base_addr[25:6], 6'b0};
        base_q    <= {base_addr[25:6], 6'b0};
        remaining <= num_bursts;
        count_q   <= num_bursts;
      end
      if (accept)    cur_addr  <= cur_addr + SDRAM_ADDR_W'(BURST_BYTES);
      if (burst_end) remaining <= remaining - COUNT_W'(1);
      if (reload) begin
        cur_addr  <= base_q;
        remaining <= count_q;
      end
      if (push)               word_cnt <= m_complete ? '0 : word_cnt + WC_W'(1);
      else if (state != DATA) word_cnt <= '0;
      if (push && (m_complete ? (word_cnt != WC_W'(BURST_WORDS - 1))
                              : (word_cnt == WC_W'(BURST_WORDS - 1))))
        err <= 1'b1;
      if (push && fifo_full) err <= 1'b1;
    end
  end

  stream_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (out_ready),
    .flush (flush),
    .wdata (m_rdata),
    .rdata (out_data),
    .valid (out_valid),
    .full  (fifo_full),
    .level (fifo_level)
  );
endmodule

// File: tb/tb_sdram_scanout_reader.sv
// Scoreboard bench: a responder plays the arbiter/SDRAM and queues every word it
// returns; a monitor pops and compares words as they leave the stream port.
module tb_sdram_scanout_reader;
  localparam int DEPTH = 64;
  localparam int CW    = 20;

  logic          clk = 1'b0;
  logic          reset, start, stop, stop_main, stop_r;
  logic [25:0]   base_addr;
  logic [CW-1:0] num_bursts;
  logic          busy, done, err, m_request, m_ready, m_write, m_burst;
  logic [25:0]   m_address, m_raddress;
  logic [31:0]   m_wdata, m_rdata, out_data;
  logic [3:0]    m_wstrb;
  logic          m_rvalid, m_complete, out_valid, out_ready;
  logic [6:0]    fifo_level;

  int total = 0, bad = 0;
  logic [31:0] exp_q[$];
  logic [25:0] addr_q[$];
  int accept_cnt = 0, max_accept = 1 << 30, pop_cnt = 0, done_cnt = 0;
  int rdy_mode = 1, cut_at = 16, abort_word = 0, stale_req = 0;
  bit keep_data = 1'b1;

  assign stop = stop_main | stop_r;
  always #5 clk = ~clk;

  sdram_scanout_reader #(.FIFO_DEPTH(DEPTH), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .base_addr(base_addr),
    .num_bursts(num_bursts), .busy(busy), .done(done), .err(err),
    .m_request(m_request), .m_ready(m_ready), .m_write(m_write), .m_burst(m_burst),
    .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rvalid(m_rvalid),
    .m_raddress(m_raddress), .m_rdata(m_rdata), .m_complete(m_complete),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_level(fifo_level)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Monitor: decide out_ready for the coming edge and check the word it will pop.
  initial begin : monitor
    bit r;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       r = 1'b0;
        1:       r = 1'b1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (r && out_valid === 1'b1) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL out_data: got unexpected word %0h, required none", out_data);
        end else chk("out_data", out_data, exp_q.pop_front());
      end
      out_ready = r;
    end
  end

  // Responder: accepts requests, returns bursts with random gaps.
  initial begin : responder
    logic [25:0] cur;
    int stale_seen;
    stale_seen = 0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_complete = 1'b0; stop_r = 1'b0;
    m_rdata = '0; m_raddress = '0;
    forever begin
      @(negedge clk);
      if (stale_req != stale_seen) begin
        for (int i = 0; i < 3; i++) begin
          m_rvalid = 1'b1; m_rdata = $urandom; m_complete = (i == 2);
          @(negedge clk);
        end
        m_rvalid = 1'b0; m_complete = 1'b0;
        stale_seen = stale_req;
      end else if (m_request === 1'b1 && accept_cnt < max_accept && $urandom_range(0, 1) == 1) begin
        if (addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL req_addr: got unexpected request at %0h, required none", m_address);
        end else chk("req_addr", m_address, addr_q.pop_front());
        chk("req_kind", {m_write, m_burst}, 2'b01);
        cur = m_address;
        m_ready = 1'b1;
        accept_cnt++;
        @(negedge clk);
        m_ready = 1'b0;
        for (int w = 0; w < cut_at; w++) begin
          while ($urandom_range(0, 3) == 0) @(negedge clk);
          m_rvalid = 1'b1; m_rdata = $urandom; m_raddress = cur + 26'(4 * w);
          m_complete = (w == cut_at - 1);
          stop_r = (w + 1 == abort_word);
          if (keep_data) exp_q.push_back(m_rdata);
          @(negedge clk);
          m_rvalid = 1'b0; m_complete = 1'b0; stop_r = 1'b0;
        end
      end
    end
  end

  task automatic run(input logic [25:0] base, input int n, input int nexp, input bit keep);
    for (int i = 0; i < nexp; i++) addr_q.push_back({base[25:6], 6'b0} + 26'(64 * (i % n)));
    keep_data = keep;
    @(negedge clk);
    base_addr = base; num_bursts = CW'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
    chk(name, busy, 0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid !== 1'b0) && n < 5000) begin @(negedge clk); n++; end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : main
    int d0, a0, p0, n;
    reset = 1'b1; start = 1'b0; stop_main = 1'b0; base_addr = '0; num_bursts = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_req", m_request, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_addr", m_address, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_consts", {m_write, m_burst, m_wdata, m_wstrb}, {1'b0, 1'b1, 32'd0, 4'd0});
    reset = 1'b0;

    stale_req++;
    repeat (10) @(negedge clk);
    chk("stale_err", err, 0);
    chk("stale_level", fifo_level, 0);

`ifdef SDRAM_SCANOUT_LOOP_EN
    rdy_mode = 1; a0 = accept_cnt; d0 = done_cnt; max_accept = a0 + 4;
    run(26'h0002000, 2, 4, 1'b1);
    n = 0;
    while (done_cnt - d0 < 2 && n < 3000) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    chk("loop_done", done_cnt - d0, 2);
    chk("loop_accepts", accept_cnt - a0, 4);
    chk("loop_busy", busy, 1);
    stop_main = 1'b1; @(negedge clk); stop_main = 1'b0;
    wait_idle("loop_stop_idle");
    wait_drain("loop_drain");
    max_accept = 1 << 30;
`else
    // Single burst with request latency.
    rdy_mode = 1; d0 = done_cnt; p0 = pop_cnt;
    run(26'h0001000, 1, 1, 1'b1);
    chk("lat_cycle1", m_request, 0);
    @(negedge clk);
    chk("lat_cycle2", m_request, 1);
    wait_idle("single_idle");
    wait_drain("single_drain");
    chk("single_done", done_cnt - d0, 1);
    chk("single_words", pop_cnt - p0, 16);

    // Misaligned base, random consumer.
    rdy_mode = 2; d0 = done_cnt;
    run(26'h0001024, 2, 2, 1'b1);
    wait_idle("misalign_idle");
    wait_drain("misalign_drain");
    chk("misalign_done", done_cnt - d0, 1);

    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 4);
      run(26'($urandom), n, n, 1'b1);
      wait_idle("rand_idle");
      wait_drain("rand_drain");
    end

    // Backpressure: FIFO fills after four bursts and requesting stalls.
    rdy_mode = 0; a0 = accept_cnt; p0 = pop_cnt;
    run(26'($urandom), 8, 8, 1'b1);
    repeat (400) @(negedge clk);
    chk("bp_accepts", accept_cnt - a0, 4);
    chk("bp_level", fifo_level, 64);
    chk("bp_req", m_request, 0);
    rdy_mode = 2;
    wait_idle("bp_idle");
    wait_drain("bp_drain");
    chk("bp_words", pop_cnt - p0, 128);

    // Zero bursts: done only.
    d0 = done_cnt; a0 = accept_cnt;
    @(negedge clk); num_bursts = '0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("zero_done", done_cnt - d0, 1);
    chk("zero_busy", busy, 0);

    // start and stop together: nothing happens.
    d0 = done_cnt;
    @(negedge clk); num_bursts = CW'(3); start = 1'b1; stop_main = 1'b1;
    @(negedge clk); start = 1'b0; stop_main = 1'b0;
    repeat (5) @(negedge clk);
    chk("ss_busy", busy, 0);
    chk("ss_quiet", {accept_cnt - a0, done_cnt - d0}, 0);

    // stop while requesting and never accepted.
    max_accept = accept_cnt;
    run(26'h0003000, 2, 0, 1'b1);
    n = 0;
    while (m_request !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    stop_main = 1'b1; @(negedge clk); stop_main = 1'b0;
    chk("reqstop_req", m_request, 0);
    chk("reqstop_busy", busy, 0);
    max_accept = 1 << 30;

    // Abort on 5th word of first of four bursts.
    rdy_mode = 0; abort_word = 5; a0 = accept_cnt; d0 = done_cnt;
    run(26'h0004000, 4, 1, 1'b0);
    wait_idle("abort_idle");
    repeat (10) @(negedge clk);
    chk("abort_accepts", accept_cnt - a0, 1);
    chk("abort_level", fifo_level, 0);
    chk("abort_done", done_cnt - d0, 0);
    chk("abort_valid", out_valid, 0);
    abort_word = 0; rdy_mode = 1;

    // Short burst sets sticky err.
    cut_at = 10; d0 = done_cnt;
    run(26'h0005000, 1, 1, 1'b1);
    wait_idle("short_idle");
    wait_drain("short_drain");
    chk("short_err", err, 1);
    chk("short_done", done_cnt - d0, 1);
    cut_at = 16;
    run(26'h0006000, 1, 1, 1'b1);
    wait_idle("sticky_idle");
    wait_drain("sticky_drain");
    chk("err_sticky", err, 1);
    pulse_reset();
    chk("err_cleared", err, 0);

    // Sixteenth word without m_complete also sets err.
    cut_at = 17;
    run(26'h0007000, 1, 1, 1'b1);
    wait_idle("long_idle");
    wait_drain("long_drain");
    chk("long_err", err, 1);
    cut_at = 16;
    pulse_reset();
`endif
    chk("addr_q_left", addr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_scanout_reader.md
# sdram_scanout_reader

Read-only streaming master for the SDRAM arbiter. It issues consecutive 64-byte burst reads over a contiguous region and buffers the returned words in an internal FIFO. The words leave on a valid/ready stream for a consumer such as video scanout or a DMA sink. It occupies one master slot on the arbiter and never writes.

## Interface
- FIFO_DEPTH, 64, FIFO entries in 32-bit words; power of two, minimum 32.
- COUNT_W, 20, width of the burst-count input.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins a transfer when idle
- stop  in  1  one-cycle pulse; aborts the current transfer
- base_addr  in  26  region start byte address; bits [5:0] ignored
- num_bursts  in  COUNT_W  number of 16-word bursts; 0 means no transfer
- busy  out  1  transfer or abort in progress
- done  out  1  one-cycle pulse on normal completion
- err  out  1  sticky; cleared only by reset
- m_request  out  1  arbiter request
- m_ready  in  1  request accepted this cycle
- m_write  out  1  constant 0
- m_burst  out  1  constant 1
- m_address  out  26  burst address, 64-byte aligned
- m_wdata  out  32  constant 0 (read tag)
- m_wstrb  out  4  constant 0
- m_rvalid  in  1  read word valid
- m_raddress  in  26  address of returned word
- m_rdata  in  32  returned word
- m_complete  in  1  last word of burst
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts word
- out_data  out  32  FIFO head (show-ahead)
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries

## Operation
- States: IDLE, REQ, DATA, DRAIN.
- IDLE:
  - start with num_bursts≠0 latches base_addr[25:6]&6'b0 as the current address and latches num_bursts as the remaining count, then goes to REQ.
  - start with num_bursts=0: stays in IDLE and pulses done.
  - start while not in IDLE is ignored.
  - If start and stop arrive in the same IDLE cycle, stop wins and nothing happens.
- REQ:
  - Registered m_request rises when FIFO_DEPTH−fifo_level ≥ 16.
  - Once m_request is high it is held, with m_address stable, until the cycle where m_request&&m_ready.
  - After that cycle: drop m_request, go to DATA, and add 64 to the address (26-bit wrap).
- DATA:
  - Each m_rvalid pushes m_rdata into the FIFO.
  - A word counter, 0..15, checks the burst: if m_complete arrives with counter≠15, or counter reaches 15 without m_complete, set err.
  - On m_rvalid&&m_complete, decrement the remaining count. At 0 go to IDLE and pulse done; otherwise go to REQ.
- Only one burst is outstanding at a time. The space check in REQ guarantees no overflow.
- If m_rvalid arrives while the FIFO is full: drop the word and set err.
- m_rvalid in IDLE or REQ (stale data after reset) is discarded and does not set err.
- stop handling:
  - In REQ: m_request drops the next cycle, the FIFO is flushed, and the block goes to IDLE.
  - In DATA: go to DRAIN. DRAIN absorbs and discards words until m_complete, then flushes the FIFO and goes to IDLE.
  - done is not pulsed on abort.
- busy = state≠IDLE.
- out: a word is popped on out_valid&&out_ready. A simultaneous push and pop leaves the level unchanged.

## Timing
- Reset values:
  - state=IDLE; busy, done, err, m_request, out_valid are 0.
  - fifo_level=0 and m_address=0.
  - m_write, m_wdata, m_wstrb are 0; m_burst is 1.
- Request latency:
  - start to m_request high takes 2 cycles when the FIFO has space.
  - After an accept, the next m_request comes no earlier than 1 cycle after the m_complete beat.
- A word pushed in cycle N gives out_valid/out_data in cycle N+1.
- done is asserted in the cycle after the final m_complete.
- fifo_level is registered and reflects pushes and pops of the previous cycle.

## Configuration
- SDRAM_SCANOUT_LOOP_EN defined: on normal completion, done still pulses, and the block reloads the latched base address and burst count and returns to REQ instead of IDLE (continuous scanout). stop is the only exit.
- SDRAM_SCANOUT_LOOP_EN undefined: the block returns to IDLE after the last burst.

## Structure
- Shared package sdram_pkg holds:
  - SDRAM_ADDR_W=26, BURST_WORDS=16, BURST_BYTES=64;
  - the state enum typedef scanout_state_t.
- Sub-module stream_fifo: synchronous show-ahead FIFO with push, pop, flush and level. It sits beside the FSM and address/counter logic.

## Test plan
- Single burst: base_addr=0x0001000, num_bursts=1, out_ready=1 → one request at 0x0001000 with m_write=0 and m_burst=1; 16 words out in order; done pulses once; busy falls.
- Backpressure: num_bursts=8, out_ready=0, FIFO_DEPTH=64 → exactly 4 accepted requests, fifo_level=64, m_request stays low. Raising out_ready resumes; 128 words total, in order.
- Misaligned base: base_addr=0x0001024 → first m_address=0x0001000, second 0x0001040.
- Abort: stop pulsed on the 5th word of burst 1 of 4 → remaining 11 words absorbed, no further request, fifo_level=0, done never pulses, busy low after m_complete+1.
- Protocol error: m_complete arrives on the 10th word → err=1 and stays 1 until reset; a FIFO push while full also sets err.
- With SDRAM_SCANOUT_LOOP_EN: num_bursts=2 at 0x0002000 → request sequence 0x0002000, 0x0002040, 0x0002000; done pulses after every second burst.
